// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse generator/capture pair: default widths,
// edge-record field layout and the capture serializer state encoding.
package pulse_pkg;

   localparam int COUNT_BITS_DEF = 32;
   localparam int CH_LOG2_DEF    = 3;
   localparam int FIFO_LOG2_DEF  = 4;
   localparam int CH_MAX_DEF     = 1 << CH_LOG2_DEF;
   localparam int REC_BITS_DEF   = 2 * COUNT_BITS_DEF + CH_LOG2_DEF + 1;

   // Edge record layout: {outer_count, count, channel, polarity}
   localparam int REC_POL_BIT = 0;
   localparam int REC_CH_LSB  = 1;

   function automatic int rec_count_lsb(input int ch_log2);
      return ch_log2 + 1;
   endfunction

   function automatic int rec_outer_lsb(input int ch_log2, input int count_bits);
      return ch_log2 + count_bits + 1;
   endfunction

   typedef enum logic {
      SER_IDLE = 1'b0,
      SER_EMIT = 1'b1
   } ser_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data. A push while full
// is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q;
   logic [DEPTH_LOG2-1:0] rd_ptr_q;
   logic [DEPTH_LOG2:0]   level_q;
   logic                  do_push;
   logic                  do_pop;

   assign full     = (level_q == (DEPTH_LOG2 + 1)'(DEPTH));
   assign empty    = (level_q == '0);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset: the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/pulse_capture.sv
// Edge timestamper: detects level changes on each channel, stamps them with
// the generator's count/outer_count timebase and streams one record per edge.
module pulse_capture
   import pulse_pkg::*;
#(
   parameter int COUNT_BITS = COUNT_BITS_DEF,
   parameter int CH_LOG2    = CH_LOG2_DEF,
   parameter int FIFO_LOG2  = FIFO_LOG2_DEF,
   localparam int CH_MAX    = 1 << CH_LOG2,
   localparam int REC_BITS  = 2 * COUNT_BITS + CH_LOG2 + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [COUNT_BITS-1:0] period,
   input  logic [COUNT_BITS-1:0] outer_period,
   input  logic [CH_MAX-1:0]     state0,
   input  logic                  arm,
   input  logic [CH_MAX-1:0]     sig_in,
   output logic                  ed_valid,
   input  logic                  ed_ready,
   output logic [REC_BITS-1:0]   ed_data,
   output logic                  overflow,
   output logic [15:0]           drop_count,
   output ser_state_e            dbg_state
);

   localparam int SNAP_W    = 2 * CH_MAX + 2 * COUNT_BITS;
   localparam int CNT_LSB   = rec_count_lsb(CH_LOG2);
   localparam int OUTER_LSB = rec_outer_lsb(CH_LOG2, COUNT_BITS);

   logic [COUNT_BITS-1:0] count_q, count_d;
   logic [COUNT_BITS-1:0] outer_q, outer_d;
   logic                  cnt_wrap;
   logic [CH_MAX-1:0]     sig_prev_q;
   logic [CH_MAX-1:0]     chg;
   logic                  snap_push;
   logic [SNAP_W-1:0]     snap_data;
   logic                  fifo_pop;
   logic [SNAP_W-1:0]     fifo_rd_data;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  drop;
   logic                  overflow_q;
   logic [15:0]           drop_cnt_q;

   ser_state_e            state_q, state_d;
   logic [CH_MAX-1:0]     mask_q, mask_d;
   logic [CH_MAX-1:0]     lvl_q, lvl_d;
   logic [COUNT_BITS-1:0] ts_count_q, ts_count_d;
   logic [COUNT_BITS-1:0] ts_outer_q, ts_outer_d;
   logic [CH_LOG2-1:0]    sel_ch;
   logic [CH_MAX-1:0]     mask_clr;

   // Timebase: outer wrap takes priority over the inner-wrap increment.
   always_comb begin
      cnt_wrap = (count_q >= period);
      count_d  = cnt_wrap ? '0 : count_q + COUNT_BITS'(1);
      if (outer_q >= outer_period) outer_d = '0;
      else if (cnt_wrap)           outer_d = outer_q + COUNT_BITS'(1);
      else                         outer_d = outer_q;
   end

   assign chg       = sig_in ^ sig_prev_q;
   assign snap_push = arm & (|chg);
   assign snap_data = {chg, sig_in, count_q, outer_q};
   assign drop      = snap_push & fifo_full & ~fifo_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q    <= '0;
         outer_q    <= '0;
         sig_prev_q <= state0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         count_q    <= count_d;
         outer_q    <= outer_d;
         sig_prev_q <= sig_in;
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
         end
      end
   end

   sync_fifo #(
      .WIDTH      (SNAP_W),
      .DEPTH_LOG2 (FIFO_LOG2)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (snap_push),
      .push_data (snap_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Lowest pending channel goes first.
   always_comb begin
      sel_ch = '0;
      for (int i = CH_MAX - 1; i >= 0; i--) begin
         if (mask_q[i]) sel_ch = CH_LOG2'(i);
      end
      mask_clr = mask_q & ~(CH_MAX'(1) << sel_ch);
   end

   // Stream: ed_valid holds and ed_data is frozen until ed_valid & ed_ready.
   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      lvl_d      = lvl_q;
      ts_count_d = ts_count_q;
      ts_outer_d = ts_outer_q;
      fifo_pop   = 1'b0;
      ed_valid   = 1'b0;
      ed_data    = '0;
      case (state_q)
         SER_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               {mask_d, lvl_d, ts_count_d, ts_outer_d} = fifo_rd_data;
               state_d = SER_EMIT;
            end
         end
         SER_EMIT: begin
            ed_valid = 1'b1;
            ed_data[REC_POL_BIT]                = lvl_q[sel_ch];
            ed_data[REC_CH_LSB +: CH_LOG2]      = sel_ch;
            ed_data[CNT_LSB +: COUNT_BITS]      = ts_count_q;
            ed_data[OUTER_LSB +: COUNT_BITS]    = ts_outer_q;
            if (ed_ready) begin
               mask_d = mask_clr;
               if (mask_clr == '0) begin
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     {mask_d, lvl_d, ts_count_d, ts_outer_d} = fifo_rd_data;
                  end else begin
                     state_d = SER_IDLE;
                  end
               end
            end
         end
         default: state_d = SER_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= SER_IDLE;
         mask_q     <= '0;
         lvl_q      <= '0;
         ts_count_q <= '0;
         ts_outer_q <= '0;
      end else begin
         state_q    <= state_d;
         mask_q     <= mask_d;
         lvl_q      <= lvl_d;
         ts_count_q <= ts_count_d;
         ts_outer_q <= ts_outer_d;
      end
   end

   assign overflow   = overflow_q;
   assign drop_count = drop_cnt_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_pulse_capture.sv
// Bench for pulse_capture: directed scenarios plus randomized traffic checked
// against a per-cycle reference of the timebase and edge-record rules.
module tb_pulse_capture;
   import pulse_pkg::*;

   typedef logic [67:0] rec_t;

   logic        clk;
   logic        reset;
   logic [31:0] period;
   logic [31:0] outer_period;
   logic [7:0]  state0;
   logic        arm;
   logic [7:0]  sig_in;
   logic        ed_valid;
   logic        ed_ready;
   rec_t        ed_data;
   logic        overflow;
   logic [15:0] drop_count;
   ser_state_e  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   rec_t exp_q[$];
   rec_t obs_q[$];
   int   obs_cyc[$];
   int   cyc = 0;

   pulse_capture dut (
      .clk          (clk),
      .reset        (reset),
      .period       (period),
      .outer_period (outer_period),
      .state0       (state0),
      .arm          (arm),
      .sig_in       (sig_in),
      .ed_valid     (ed_valid),
      .ed_ready     (ed_ready),
      .ed_data      (ed_data),
      .overflow     (overflow),
      .drop_count   (drop_count),
      .dbg_state    (dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic rec_t mk_rec(input logic [31:0] outer, input logic [31:0] cnt,
                                   input logic [2:0] ch, input logic pol);
      return {outer, cnt, ch, pol};
   endfunction

   // Reference: timebase rule plus one record per changed channel, ascending.
   logic [31:0] m_count, m_outer;
   logic [7:0]  m_prev, m_chg;
   initial begin
      m_count = 0; m_outer = 0; m_prev = 0; m_chg = 0;
      forever begin
         @(posedge clk);
         if (reset) begin
            exp_q.delete();
            m_count = 0;
            m_outer = 0;
            m_prev  = state0;
         end else begin
            m_chg = sig_in ^ m_prev;
            if (arm && m_chg != 0) begin
               for (int c = 0; c < 8; c++)
                  if (m_chg[c]) exp_q.push_back(mk_rec(m_outer, m_count, 3'(c), sig_in[c]));
            end
            m_prev = sig_in;
            if (m_outer >= outer_period) m_outer = 0;
            else if (m_count >= period)  m_outer = m_outer + 1;
            if (m_count >= period) m_count = 0;
            else                   m_count = m_count + 1;
         end
      end
   end

   // Collect every record accepted by the consumer.
   initial begin
      forever begin
         @(negedge clk);
         cyc = cyc + 1;
         if (reset) begin
            obs_q.delete();
            obs_cyc.delete();
         end else if (ed_valid && ed_ready) begin
            obs_q.push_back(ed_data);
            obs_cyc.push_back(cyc);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit ok);
      int quiet = 0;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         step(1);
         quiet = ed_valid ? 0 : quiet + 1;
         if (quiet >= 3) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      period = 9; outer_period = 3; state0 = 8'h00; arm = 1'b1;
      sig_in = 8'h00; ed_ready = 1'b1;
      reset = 1'b1;
      step(2);
      n_tests++;
      if (ed_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ed_valid); end
      n_tests++;
      if (ed_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", ed_data); end
      n_tests++;
      if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
      n_tests++;
      if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drops got %0d want 0", drop_count); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      bit ok;
      rec_t want;
      want = mk_rec(32'd0, 32'd5, 3'd2, 1'b1);
      sig_in = 8'h00; ed_ready = 1'b1;
      do_reset();
      step(5);
      sig_in = 8'h04;
      step(1);
      n_tests++;
      if (ed_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", ed_valid); end
      step(1);
      n_tests++;
      if (ed_valid !== 1'b1 || ed_data !== want) begin
         n_fail++; $display("FAIL single_latency got v=%b d=%h want v=1 d=%h", ed_valid, ed_data, want);
      end
      wait_idle(50, ok);
      n_tests++;
      if (!ok || obs_q.size() != 1) begin
         n_fail++; $display("FAIL single_count got %0d records (idle=%b) want 1", obs_q.size(), ok);
      end else begin
         n_tests++;
         if (obs_q[0] !== want) begin n_fail++; $display("FAIL single_rec got %h want %h", obs_q[0], want); end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      rec_t w0, w1;
      w0 = mk_rec(32'd0, 32'd3, 3'd0, 1'b1);
      w1 = mk_rec(32'd0, 32'd3, 3'd7, 1'b1);
      sig_in = 8'h00; ed_ready = 1'b1;
      do_reset();
      step(3);
      sig_in = 8'h81;
      wait_idle(50, ok);
      n_tests++;
      if (!ok || obs_q.size() != 2) begin
         n_fail++; $display("FAIL b2b_count got %0d records (idle=%b) want 2", obs_q.size(), ok);
      end else begin
         n_tests++;
         if (obs_q[0] !== w0) begin n_fail++; $display("FAIL b2b_first got %h want %h", obs_q[0], w0); end
         n_tests++;
         if (obs_q[1] !== w1) begin n_fail++; $display("FAIL b2b_second got %h want %h", obs_q[1], w1); end
         n_tests++;
         if (obs_cyc[1] != obs_cyc[0] + 1) begin
            n_fail++; $display("FAIL b2b_gap got cycles %0d,%0d want consecutive", obs_cyc[0], obs_cyc[1]);
         end
      end
   endtask

   task automatic test_hold();
      bit ok;
      rec_t held;
      sig_in = 8'h00; ed_ready = 1'b0;
      do_reset();
      step(2);
      sig_in = 8'h10;
      step(3);
      held = ed_data;
      n_tests++;
      if (ed_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid got %b want 1", ed_valid); end
      for (int i = 0; i < 10; i++) begin
         step(1);
         n_tests++;
         if (ed_valid !== 1'b1 || ed_data !== held) begin
            n_fail++; $display("FAIL hold_stable cyc %0d got v=%b d=%h want v=1 d=%h", i, ed_valid, ed_data, held);
         end
      end
      ed_ready = 1'b1;
      step(1);
      n_tests++;
      if (ed_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release got %b want 0", ed_valid); end
      wait_idle(50, ok);
      n_tests++;
      if (!ok || obs_q.size() != 1 || exp_q.size() != 1) begin
         n_fail++; $display("FAIL hold_count got %0d records want 1", obs_q.size());
      end else begin
         n_tests++;
         if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL hold_rec got %h want %h", obs_q[0], exp_q[0]); end
      end
   endtask

   task automatic test_overflow();
      bit ok;
      int toggles = 20;
      int want_drops;
      want_drops = toggles - 17;  // 16 queued in the FIFO plus one held in the serializer
      sig_in = 8'h00; ed_ready = 1'b0;
      do_reset();
      for (int i = 0; i < toggles; i++) begin
         sig_in = sig_in ^ 8'h02;
         step(2);
      end
      n_tests++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
      n_tests++;
      if (drop_count !== 16'(want_drops)) begin
         n_fail++; $display("FAIL ovf_drops got %0d want %0d", drop_count, want_drops);
      end
      ed_ready = 1'b1;
      wait_idle(200, ok);
      n_tests++;
      if (!ok || obs_q.size() != exp_q.size() - want_drops) begin
         n_fail++; $display("FAIL ovf_drain got %0d records want %0d", obs_q.size(), exp_q.size() - want_drops);
      end else begin
         for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_rec %0d got %h want %h", i, obs_q[i], exp_q[i]); end
         end
      end
      n_tests++;
      if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
   endtask

   task automatic test_timebase();
      bit ok;
      rec_t want;
      want = mk_rec(32'd1, 32'd0, 3'd5, 1'b1);
      period = 2; outer_period = 1;
      sig_in = 8'h00; ed_ready = 1'b1;
      do_reset();
      step(3);
      sig_in = 8'h20;
      for (int i = 0; i < 30; i++) begin
         step(1);
         if ($urandom_range(0, 2) == 0) sig_in = sig_in ^ (8'h01 << $urandom_range(0, 7));
         ed_ready = ($urandom_range(0, 3) != 0);
      end
      ed_ready = 1'b1;
      wait_idle(200, ok);
      n_tests++;
      if (!ok || obs_q.size() == 0 || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL tb_count got %0d records want %0d", obs_q.size(), exp_q.size());
      end else begin
         n_tests++;
         if (obs_q[0] !== want) begin n_fail++; $display("FAIL tb_first got %h want %h", obs_q[0], want); end
         for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL tb_rec %0d got %h want %h", i, obs_q[i], exp_q[i]); end
         end
      end
   endtask

   task automatic test_arm_reset();
      bit ok;
      rec_t want;
      want = mk_rec(32'd0, 32'd0, 3'd0, 1'b1);
      period = 9; outer_period = 3;
      arm = 1'b0; sig_in = 8'h00; ed_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         sig_in = sig_in ^ 8'(1 << $urandom_range(0, 7));
         step(1);
      end
      wait_idle(50, ok);
      n_tests++;
      if (!ok || obs_q.size() != 0) begin n_fail++; $display("FAIL disarm_records got %0d want 0", obs_q.size()); end
      arm = 1'b1; ed_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         sig_in = sig_in ^ 8'h08;
         step(2);
      end
      ed_ready = 1'b1;
      step(2);
      reset = 1'b1;
      sig_in = 8'h00;
      step(1);
      n_tests++;
      if (ed_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", ed_valid); end
      n_tests++;
      if (overflow !== 1'b0 || drop_count !== 16'd0) begin
         n_fail++; $display("FAIL rst_ovf got ovf=%b drops=%0d want 0,0", overflow, drop_count);
      end
      step(1);
      reset = 1'b0;
      sig_in = 8'h01;
      wait_idle(50, ok);
      n_tests++;
      if (!ok || obs_q.size() != 1) begin
         n_fail++; $display("FAIL rst_count got %0d records want 1", obs_q.size());
      end else begin
         n_tests++;
         if (obs_q[0] !== want) begin n_fail++; $display("FAIL rst_stamp got %h want %h", obs_q[0], want); end
      end
   endtask

   task automatic test_random();
      bit ok;
      logic [7:0] m;
      period = $urandom_range(1, 6);
      outer_period = $urandom_range(0, 3);
      state0 = 8'($urandom_range(0, 255));
      sig_in = state0; arm = 1'b1; ed_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         m = 8'h00;
         for (int b = 0; b < 8; b++) if ($urandom_range(0, 31) == 0) m[b] = 1'b1;
         sig_in = sig_in ^ m;
         if ($urandom_range(0, 19) == 0) arm = ~arm;
         ed_ready = ($urandom_range(0, 3) != 0);
         step(1);
      end
      arm = 1'b1; ed_ready = 1'b1;
      wait_idle(300, ok);
      n_tests++;
      if (drop_count !== 16'd0) begin n_fail++; $display("FAIL rand_drops got %0d want 0", drop_count); end
      n_tests++;
      if (!ok || obs_q.size() != exp_q.size()) begin
         n_fail++; $display("FAIL rand_count got %0d records want %0d", obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < obs_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_rec %0d got %h want %h", i, obs_q[i], exp_q[i]); end
         end
      end
   endtask

   initial begin
      reset = 1'b1; period = 9; outer_period = 3; state0 = 8'h00;
      arm = 1'b1; sig_in = 8'h00; ed_ready = 1'b1;
      step(1);
      test_reset();
      test_single();
      test_back_to_back();
      test_hold();
      test_overflow();
      test_timebase();
      test_arm_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
